// File: rtl/ysyx_23060180_core_pkg.sv
// Shared opcodes, FSM encodings, halt codes and ALU ops
// for the ysyx_23060180 multi-cycle core.
package ysyx_23060180_core_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  typedef logic [2:0] state_e;
  localparam state_e S_FETCH  = 3'd0;
  localparam state_e S_IWAIT  = 3'd1;
  localparam state_e S_DECODE = 3'd2;
  localparam state_e S_EXEC   = 3'd3;
  localparam state_e S_MEM    = 3'd4;
  localparam state_e S_MWAIT  = 3'd5;
  localparam state_e S_WB     = 3'd6;
  localparam state_e S_HALT   = 3'd7;

  localparam logic [1:0] HC_NONE     = 2'd0;
  localparam logic [1:0] HC_EBREAK   = 2'd1;
  localparam logic [1:0] HC_ILLEGAL  = 2'd2;
  localparam logic [1:0] HC_MISALIGN = 2'd3;

  typedef enum logic {ALU_ADD, ALU_SUB} alu_op_e;

  function automatic logic [31:0] sext12(
    input logic [11:0] v
  );
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_23060180_regfile.sv
// Architectural register file: 2 async reads, 1 sync write,
// x0 hardwired to zero.
module ysyx_23060180_regfile
  import ysyx_23060180_core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

  function automatic logic [XLEN-1:0] reg_value(
    input logic [AW-1:0] idx
  );
    return regs[idx];
  endfunction

endmodule

// File: rtl/ysyx_23060180_mc_core.sv
// Multi-cycle RV32I-subset core with handshaked imem/dmem ports.
// Define YSYX_CORE_PERF_EN to add perf_cycle/perf_instret counters.
module ysyx_23060180_mc_core
  import ysyx_23060180_core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rstn_in,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_rvalid,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wmask,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_rvalid,
  output logic            halted,
  output logic [1:0]      halt_code,
  output logic            retire,
  output logic [XLEN-1:0] retire_pc
`ifdef YSYX_CORE_PERF_EN
 ,output logic [63:0]     perf_cycle,
  output logic [63:0]     perf_instret
`endif
);

  localparam int AW = $clog2(NREGS);

  if (XLEN != 32) begin : g_xlen_chk
    $fatal(1, "XLEN must be 32");
  end

  logic [1:0] rsync;
  logic       rst_n;

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) rsync <= 2'b00;
    else          rsync <= {rsync[0], 1'b1};
  end
  assign rst_n = rsync[1];

  state_e          state;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc, rs1v, rs2v, res, tgt;
  logic [XLEN-1:0] rd1, rd2, op1, op2, alu_y;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_imm, is_reg, is_ld, is_st, is_ebrk;
  logic use_rs1, use_rs2, use_rd, e_bad, legal;
  logic aligned, mem_act;
  alu_op_e aop;

  always_comb begin
    opc      = instr[6:0];
    f3       = instr[14:12];
    f7       = instr[31:25];
    is_lui   = opc == OP_LUI;
    is_auipc = opc == OP_AUIPC;
    is_jal   = opc == OP_JAL;
    is_jalr  = opc == OP_JALR && f3 == 3'b000;
    is_imm   = opc == OP_IMM && f3 == 3'b000;
    is_reg   = opc == OP_REG && f3 == 3'b000 &&
               (f7 == 7'b0000000 || f7 == 7'b0100000);
    is_ld    = opc == OP_LOAD && f3 == 3'b010;
    is_st    = opc == OP_STORE && f3 == 3'b010;
    is_ebrk  = instr == EBREAK;
    use_rs1  = is_jalr | is_imm | is_reg | is_ld | is_st;
    use_rs2  = is_reg | is_st;
    use_rd   = is_lui | is_auipc | is_jal | is_jalr |
               is_imm | is_reg | is_ld;
    // RV32E: any referenced register above x15 is illegal
    e_bad    = (NREGS == 16) &&
               ((use_rd  && instr[11]) ||
                (use_rs1 && instr[19]) ||
                (use_rs2 && instr[24]));
    legal    = (use_rd | is_st | is_ebrk) && !e_bad;
  end

  always_comb begin
    aop = (is_reg && instr[30]) ? ALU_SUB : ALU_ADD;
    op1 = rs1v;
    op2 = sext12(instr[31:20]);
    unique case (1'b1)
      is_lui: begin
        op1 = '0;
        op2 = {instr[31:12], 12'b0};
      end
      is_auipc: begin
        op1 = pc;
        op2 = {instr[31:12], 12'b0};
      end
      is_reg:  op2 = rs2v;
      is_st:   op2 = sext12({instr[31:25], instr[11:7]});
      default: ;
    endcase
    alu_y = (aop == ALU_SUB) ? op1 - op2 : op1 + op2;
  end

  ysyx_23060180_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (instr[15 +: AW]),
    .ra2   (instr[20 +: AW]),
    .we    (state == S_WB && use_rd),
    .wa    (instr[7 +: AW]),
    .wd    (res),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      instr     <= '0;
      rs1v      <= '0;
      rs2v      <= '0;
      res       <= '0;
      tgt       <= '0;
      halted    <= 1'b0;
      halt_code <= HC_NONE;
    end else begin
      unique case (state)
        S_FETCH: state <= S_IWAIT;
        S_IWAIT: if (imem_rvalid) begin
          instr <= imem_rdata;
          state <= S_DECODE;
        end
        S_DECODE: if (legal) begin
          rs1v  <= rd1;
          rs2v  <= rd2;
          state <= S_EXEC;
        end else begin
          state     <= S_HALT;
          halted    <= 1'b1;
          halt_code <= HC_ILLEGAL;
        end
        S_EXEC: begin
          res <= (is_jal | is_jalr) ? pc + XLEN'(4) : alu_y;
          if (is_jal)
            tgt <= pc + {{12{instr[31]}}, instr[19:12],
                         instr[20], instr[30:21], 1'b0};
          else if (is_jalr)
            tgt <= (rs1v + sext12(instr[31:20])) & ~XLEN'(1);
          else
            tgt <= pc + XLEN'(4);
          state <= (is_ld | is_st) ? S_MEM : S_WB;
        end
        S_MEM: if (!aligned) begin
          state     <= S_HALT;
          halted    <= 1'b1;
          halt_code <= HC_MISALIGN;
        end else begin
          state <= S_MWAIT;
        end
        S_MWAIT: if (dmem_rvalid) begin
          if (is_ld) res <= dmem_rdata;
          state <= S_WB;
        end
        S_WB: begin
          pc <= tgt;
          if (is_ebrk) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            halt_code <= HC_EBREAK;
          end else begin
            state <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign aligned    = res[1:0] == 2'b00;
  assign mem_act    = (state == S_MEM && aligned) ||
                      state == S_MWAIT;
  assign imem_req   = rst_n && state == S_FETCH;
  assign imem_addr  = pc;
  assign dmem_req   = state == S_MEM && aligned;
  assign dmem_we    = mem_act && is_st;
  assign dmem_addr  = mem_act ? res : '0;
  assign dmem_wdata = dmem_we ? rs2v : '0;
  assign dmem_wmask = dmem_we ? 4'b1111 : 4'b0000;
  assign retire     = state == S_WB;
  assign retire_pc  = retire ? pc : '0;

`ifdef YSYX_CORE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycle   <= '0;
      perf_instret <= '0;
    end else begin
      if (state != S_HALT) perf_cycle <= perf_cycle + 64'd1;
      if (retire) perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060180_mc_core.sv
// Directed bench for ysyx_23060180_mc_core with latency-
// programmable instruction and data memory models.
module tb_ysyx_23060180_mc_core;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn_in = 1'b0;
  logic        imem_req, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_rvalid = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_wmask;
  logic        halted, retire;
  logic [1:0]  halt_code;
  logic [31:0] retire_pc;
`ifdef YSYX_CORE_PERF_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_23060180_mc_core dut (
    .clk         (clk),
    .rstn_in     (rstn_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wmask  (dmem_wmask),
    .dmem_rdata  (dmem_rdata),
    .dmem_rvalid (dmem_rvalid),
    .halted      (halted),
    .halt_code   (halt_code),
    .retire      (retire),
    .retire_pc   (retire_pc)
`ifdef YSYX_CORE_PERF_EN
   ,.perf_cycle  (perf_cycle),
    .perf_instret(perf_instret)
`endif
  );

  logic [31:0] imem [16];
  logic [31:0] dmem [16] = '{default: '0};
  int ilat = 1;
  int dlat = 1;
  logic ipend = 1'b0;
  logic dpend = 1'b0;
  int icnt, dcnt;
  logic [3:0] iidx, didx;
  int cyc, fcyc0, n_ret, n_fetch, n_dreq;
  logic [31:0] fetch_a [16];
  logic [31:0] ret_pc [16];
  int ret_cyc [16];
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_mask = '0;

  // Memory responders and event recorder, all on the falling edge
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (ipend) begin
      icnt--;
      if (icnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = imem[iidx];
        ipend       = 1'b0;
      end
    end
    if (imem_req) begin
      ipend = 1'b1;
      icnt  = ilat;
      iidx  = 4'((imem_addr - RPC) >> 2);
    end
    dmem_rvalid = 1'b0;
    if (dpend) begin
      dcnt--;
      if (dcnt == 0) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = dmem[didx];
        dpend       = 1'b0;
      end
    end
    if (dmem_req) begin
      dpend = 1'b1;
      dcnt  = dlat;
      didx  = dmem_addr[5:2];
      if (dmem_we) begin
        dmem[didx] = dmem_wdata;
        st_addr    = dmem_addr;
        st_data    = dmem_wdata;
        st_mask    = dmem_wmask;
      end
    end
    if (!rstn_in) begin
      cyc = 0; n_ret = 0; n_fetch = 0; n_dreq = 0;
    end else begin
      cyc++;
      if (imem_req) begin
        if (n_fetch == 0) fcyc0 = cyc;
        if (n_fetch < 16) fetch_a[n_fetch] = imem_addr;
        n_fetch++;
      end
      if (retire) begin
        if (n_ret < 16) begin
          ret_pc[n_ret]  = retire_pc;
          ret_cyc[n_ret] = cyc;
        end
        n_ret++;
      end
      if (dmem_req) n_dreq++;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int il, input int dl);
    rstn_in = 1'b0;
    ilat = il;
    dlat = dl;
    repeat (3) @(posedge clk);
    #2 rstn_in = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("halt_reached", halted, 1);
  endtask

  task automatic clr_imem();
    foreach (imem[i]) imem[i] = 32'h0;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_retire", retire, 0);
    chk("rst_retire_pc", retire_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_halt_code", halt_code, 0);
    chk("rst_imem_addr", imem_addr, RPC);

    // Program 1: ALU, upper-imm, store/load, jal, ebreak
    clr_imem();
    imem[0] = 32'h0050_0093;
    imem[1] = 32'hFF90_8113;
    imem[2] = 32'h0000_1217;
    imem[3] = 32'h1234_51B7;
    imem[4] = 32'h8000_12B7;
    imem[5] = 32'h0022_A223;
    imem[6] = 32'h0042_A303;
    imem[7] = 32'h0080_00EF;
    imem[8] = 32'h0000_0000;
    imem[9] = 32'h0010_0073;
    do_reset(1, 3);
    wait_halt(400);
    chk("p1_halt_code", halt_code, 1);
    chk("p1_x2", dut.u_rf.regs[2], 32'hFFFF_FFFE);
    chk("p1_x3", dut.u_rf.regs[3], 32'h1234_5000);
    chk("p1_x4", dut.u_rf.regs[4], 32'h8000_1008);
    chk("p1_x5", dut.u_rf.regs[5], 32'h8000_1000);
    chk("p1_x6", dut.u_rf.regs[6], 32'hFFFF_FFFE);
    chk("p1_x1_link", dut.u_rf.regs[1], 32'h8000_0020);
    chk("p1_st_addr", st_addr, 32'h8000_1004);
    chk("p1_st_mask", st_mask, 4'b1111);
    chk("p1_st_data", st_data, 32'hFFFF_FFFE);
    chk("p1_ret0_lat", ret_cyc[0] - fcyc0, 4);
    chk("p1_ret1_lat", ret_cyc[1] - fcyc0, 9);
    chk("p1_ret0_pc", ret_pc[0], RPC);
    chk("p1_ret1_pc", ret_pc[1], RPC + 4);
    chk("p1_sw_cycles", ret_cyc[5] - ret_cyc[4], 9);
    chk("p1_lw_cycles", ret_cyc[6] - ret_cyc[5], 9);
    chk("p1_jal_fetch", fetch_a[8], 32'h8000_0024);
    chk("p1_dmem_reqs", n_dreq, 2);
    chk("p1_last_ret_pc", ret_pc[8], 32'h8000_0024);
`ifdef YSYX_CORE_PERF_EN
    chk("p1_perf_instret", perf_instret, 9);
    chk("p1_perf_cycle", perf_cycle, 53);
`endif
    repeat (6) @(posedge clk);
    #2;
    chk("p1_retires", n_ret, 9);
    chk("p1_no_refetch", n_fetch, 9);
    chk("p1_halt_sticky", halted, 1);
`ifdef YSYX_CORE_PERF_EN
    chk("p1_perf_frozen", perf_cycle, 53);
`endif

    // Program 2: jal then jalr to an odd target
    clr_imem();
    imem[0] = 32'h0080_00EF;
    imem[1] = 32'h0010_0073;
    imem[2] = 32'h0030_8067;
    do_reset(2, 1);
    wait_halt(200);
    chk("p2_halt_code", halt_code, 1);
    chk("p2_x1", dut.u_rf.regs[1], 32'h8000_0004);
    chk("p2_fetch1", fetch_a[1], 32'h8000_0008);
    chk("p2_fetch2", fetch_a[2], 32'h8000_0006);
    chk("p2_ret2_pc", ret_pc[2], 32'h8000_0006);
    chk("p2_ret0_lat", ret_cyc[0] - fcyc0, 5);
    chk("p2_retires", n_ret, 3);

    // Program 3: misaligned load halts without a request
    clr_imem();
    imem[0] = 32'h8000_12B7;
    imem[1] = 32'h0012_A383;
    do_reset(1, 1);
    wait_halt(200);
    chk("p3_halt_code", halt_code, 3);
    chk("p3_dmem_reqs", n_dreq, 0);
    chk("p3_retires", n_ret, 1);
    chk("p3_x7", dut.u_rf.regs[7], 0);

    // Program 4: all-zero opcode is illegal
    clr_imem();
    do_reset(1, 1);
    wait_halt(200);
    chk("p4_halt_code", halt_code, 2);
    chk("p4_retires", n_ret, 0);

    // Reset asserted mid-IWAIT, late rvalid lands in reset
    clr_imem();
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h0010_0073;
    do_reset(5, 1);
    k = 0;
    while (!imem_req && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("p5_req_seen", imem_req, 1);
    repeat (2) @(posedge clk);
    #2 rstn_in = 1'b0;
    #2;
    chk("p5_rst_imem_req", imem_req, 0);
    chk("p5_rst_retire", retire, 0);
    chk("p5_rst_halted", halted, 0);
    chk("p5_rst_halt_code", halt_code, 0);
    chk("p5_rst_imem_addr", imem_addr, RPC);
    repeat (8) @(posedge clk);
    ilat = 1;
    #2 rstn_in = 1'b1;
    wait_halt(200);
    chk("p5_refetch", fetch_a[0], RPC);
    chk("p5_x1", dut.u_rf.regs[1], 5);
    chk("p5_halt_code", halt_code, 1);
    chk("p5_retires", n_ret, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
